// File: rtl/pc_unit.sv
// pc_unit: program-counter register and next-PC sequencer with a circular
// return-address stack.
//
// Ports:
//   CLK            rising-edge clock
//   Reset_n        asynchronous active-low reset
//   PCinc [15:0]   PC+1 from the external adder (combinational from PC)
//   PCWrite        advance enable; low holds PC and stack
//   Branch         take branch (BranchTarget)
//   BranchTarget   branch destination
//   Jump           unconditional jump (JumpTarget)
//   JumpTarget     jump destination, also the call destination
//   Call           push PCinc, go to JumpTarget
//   Ret            pop the return address into PC
//   ClearFlags     synchronous clear of the sticky flags
//   PC [15:0]      current program counter (registered)
//   StackDepth[4:0] valid stack entries, 0..STACK_DEPTH
//   StackOverflow  sticky: a push happened while the stack was full
//   StackUnderflow sticky: a pop happened while the stack was empty
//
// Control handshake: there is no valid/ready pair; each control input is
// sampled on a rising edge only when PCWrite=1, with fixed priority
// Ret > Call > Jump > Branch > sequential. ClearFlags is sampled every edge.
module pc_unit #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int          STACK_DEPTH = 8
) (
  input  logic        CLK,
  input  logic        Reset_n,
  input  logic [15:0] PCinc,
  input  logic        PCWrite,
  input  logic        Branch,
  input  logic [15:0] BranchTarget,
  input  logic        Jump,
  input  logic [15:0] JumpTarget,
  input  logic        Call,
  input  logic        Ret,
  input  logic        ClearFlags,
  output logic [15:0] PC,
  output logic [4:0]  StackDepth,
  output logic        StackOverflow,
  output logic        StackUnderflow
);

  localparam int          PW   = $clog2(STACK_DEPTH);
  localparam logic [4:0]  FULL = 5'(STACK_DEPTH);

  // ptr addresses the next free slot; the top entry lives at ptr-1.
  // Power-of-two depth makes the pointer wrap naturally.
  logic [15:0]   stack [STACK_DEPTH];
  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_dec;
  logic [15:0]   top;

  logic do_ret, do_call, pop_ok, set_uf, set_of;
  logic [15:0] pc_next;

  assign ptr_dec = ptr - 1'b1;
  assign top     = stack[ptr_dec];

  assign do_ret  = PCWrite & Ret;
  assign do_call = PCWrite & ~Ret & Call;
  assign pop_ok  = do_ret & (StackDepth != 5'd0);
  assign set_uf  = do_ret & (StackDepth == 5'd0);
  assign set_of  = do_call & (StackDepth == FULL);

  always_comb begin
    pc_next = PC;
    if (PCWrite) begin
      if (Ret)         pc_next = pop_ok ? top : PCinc;
      else if (Call)   pc_next = JumpTarget;
      else if (Jump)   pc_next = JumpTarget;
      else if (Branch) pc_next = BranchTarget;
      else             pc_next = PCinc;
    end
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      PC             <= RESET_PC;
      ptr            <= '0;
      StackDepth     <= 5'd0;
      StackOverflow  <= 1'b0;
      StackUnderflow <= 1'b0;
    end else begin
      PC <= pc_next;
      if (do_call) begin
        ptr <= ptr + 1'b1;
        // A full stack overwrites its oldest entry, so depth saturates.
        if (StackDepth != FULL) StackDepth <= StackDepth + 5'd1;
      end else if (pop_ok) begin
        ptr        <= ptr_dec;
        StackDepth <= StackDepth - 5'd1;
      end
      // Set dominates clear when both happen in the same cycle.
      StackOverflow  <= (StackOverflow  & ~ClearFlags) | set_of;
      StackUnderflow <= (StackUnderflow & ~ClearFlags) | set_uf;
    end
  end

  // Stack contents need no reset; gating on Reset_n keeps an edge that
  // coincides with reset from leaving a partial push behind.
  always_ff @(posedge CLK) begin
    if (Reset_n && do_call) stack[ptr] <= PCinc;
  end

endmodule
